// File: rtl/pc_predict_unit.sv
// Fetch PC generator: owns the PC register, predicts the next PC from a direct-mapped
// BTB with 2-bit counters, and redirects fetch when EX resolves a misprediction.
module pc_predict_unit #(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              PRED_EN     = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  output logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_target,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            pipeline_flush
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q [BTB_ENTRIES];
  logic [TAGW-1:0] tag_q   [BTB_ENTRIES];
  logic [XLEN-1:0] tgt_q   [BTB_ENTRIES];
  logic [1:0]      ctr_q   [BTB_ENTRIES];

  logic [IDX-1:0]  if_idx, ex_idx;
  logic [TAGW-1:0] if_tag, ex_tag;
  logic            if_hit, ex_hit;
  logic            ex_ctrl, ex_jump, act_taken, mispredict, btb_we;
  logic [XLEN-1:0] act_pc;

  // Lookup reads the registered table, so a same-cycle write is not visible here.
  assign if_idx         = pc_q[IDX+1:2];
  assign if_tag         = pc_q[XLEN-1:IDX+2];
  assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign if_pred_taken  = (PRED_EN != 0) && if_hit && ctr_q[if_idx][1];
  assign if_pred_target = if_pred_taken ? tgt_q[if_idx] : pc_q + XLEN'(4);
  assign if_pc          = pc_q;

  assign ex_ctrl        = ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr);
  assign ex_jump        = ex_is_jal || ex_is_jalr;
  assign act_taken      = ex_jump || ex_taken;
  assign act_pc         = act_taken ? ex_target : ex_pc + XLEN'(4);
  assign mispredict     = (act_taken != ex_pred_taken) || (act_pc != ex_pred_target);
  assign pipeline_flush = ex_ctrl && mispredict;

  assign ex_idx = ex_pc[IDX+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX+2];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign btb_we = ex_ctrl && (PRED_EN != 0);

  always_comb begin
    pc_d = if_pred_target;
    if (pipeline_flush) pc_d = act_pc;
    else if (stall)     pc_d = pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
    end else begin
      pc_q <= pc_d;
      if (btb_we) begin
        if (ex_hit) begin
          if (ex_jump) begin
            ctr_q[ex_idx] <= 2'b11;
            tgt_q[ex_idx] <= ex_target;
          end else if (ex_taken) begin
            if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'b01;
            tgt_q[ex_idx] <= ex_target;
          end else if (ctr_q[ex_idx] != 2'b00) begin
            ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'b01;
          end
        end else if (act_taken) begin
          // Allocation overwrites whatever occupied the slot.
          valid_q[ex_idx] <= 1'b1;
          tag_q[ex_idx]   <= ex_tag;
          tgt_q[ex_idx]   <= ex_target;
          ctr_q[ex_idx]   <= ex_jump ? 2'b11 : 2'b10;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit: reset, BTB allocation/training, JALR retarget,
// stall/flush priority, aliasing and PC wrap, with hand-computed expectations.
module tb_pc_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_taken;
  logic [31:0] ex_pc, ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        pipeline_flush;

  int n_cmp = 0;
  int n_bad = 0;

  pc_predict_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pipeline_flush(pipeline_flush)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0; ex_taken = 0;
    ex_pc = '0; ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0;
  endtask

  task automatic drive_ex(input logic br, input logic jal, input logic jalr, input logic tk,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
    ex_valid = 1; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr; ex_taken = tk;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    #1;
  endtask

  // Steer fetch to addr with a not-taken branch at addr-4 that was predicted taken.
  // Those addr-4 slots are never allocated, so the BTB is left untouched.
  task automatic redirect(input logic [31:0] addr);
    drive_ex(1, 0, 0, 0, addr - 32'd4, 32'h0, 1, 32'hdead_beec);
    check_eq("redir_flush", {31'b0, pipeline_flush}, 32'd1);
    step();
    ex_idle();
    check_eq("redir_pc", if_pc, addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; stall = 0; ex_idle();
    #23;
    check_eq("rst_pc", if_pc, 32'h0);
    check_eq("rst_pred", {31'b0, if_pred_taken}, 32'd0);
    check_eq("rst_flush", {31'b0, pipeline_flush}, 32'd0);
    @(negedge clk); rst_n = 1;
    #1;
    check_eq("rel_pc0", if_pc, 32'h0);
    check_eq("rel_tgt0", if_pred_target, 32'h4);
    step(); check_eq("seq_pc4", if_pc, 32'h4);
    step(); check_eq("seq_pc8", if_pc, 32'h8);

    // non-control and invalid instructions never flush
    drive_ex(0, 0, 0, 1, 32'h10, 32'h40, 0, 32'h0);
    check_eq("nonctrl_flush", {31'b0, pipeline_flush}, 32'd0);
    drive_ex(1, 0, 0, 1, 32'h10, 32'h40, 0, 32'h14);
    ex_valid = 0; #1;
    check_eq("invalid_flush", {31'b0, pipeline_flush}, 32'd0);

    // cold taken branch at 0x10 -> 0x40
    drive_ex(1, 0, 0, 1, 32'h10, 32'h40, 0, 32'h14);
    check_eq("cold_flush", {31'b0, pipeline_flush}, 32'd1);
    step(); ex_idle();
    check_eq("cold_pc", if_pc, 32'h40);
    redirect(32'h10);
    check_eq("hit_pred", {31'b0, if_pred_taken}, 32'd1);
    check_eq("hit_tgt", if_pred_target, 32'h40);
    step(); check_eq("pred_follow", if_pc, 32'h40);

    // training: ctr 10 -> 01 -> 00
    drive_ex(1, 0, 0, 0, 32'h10, 32'h40, 1, 32'h40);
    check_eq("nt1_flush", {31'b0, pipeline_flush}, 32'd1);
    step(); ex_idle();
    check_eq("nt1_pc", if_pc, 32'h14);
    redirect(32'h10);
    check_eq("nt_pred", {31'b0, if_pred_taken}, 32'd0);
    check_eq("nt_tgt", if_pred_target, 32'h14);
    drive_ex(1, 0, 0, 0, 32'h10, 32'h40, 0, 32'h14);
    check_eq("nt2_flush", {31'b0, pipeline_flush}, 32'd0);
    step(); ex_idle();
    check_eq("nt2_pc", if_pc, 32'h14);

    // JALR at 0x20: learn 0x100, then retarget to 0x200
    drive_ex(0, 0, 1, 0, 32'h20, 32'h100, 0, 32'h24);
    check_eq("jalr_cold_flush", {31'b0, pipeline_flush}, 32'd1);
    step(); ex_idle();
    check_eq("jalr_cold_pc", if_pc, 32'h100);
    redirect(32'h20);
    check_eq("jalr_pred", {31'b0, if_pred_taken}, 32'd1);
    check_eq("jalr_tgt", if_pred_target, 32'h100);
    drive_ex(0, 0, 1, 0, 32'h20, 32'h200, 1, 32'h100);
    check_eq("jalr_chg_flush", {31'b0, pipeline_flush}, 32'd1);
    step(); ex_idle();
    check_eq("jalr_chg_pc", if_pc, 32'h200);
    redirect(32'h20);
    check_eq("jalr_new_tgt", if_pred_target, 32'h200);

    // stall + mispredict: flush wins; then stall holds
    stall = 1;
    drive_ex(1, 0, 0, 1, 32'h10, 32'h40, 0, 32'h14);
    check_eq("stall_flush", {31'b0, pipeline_flush}, 32'd1);
    step(); ex_idle();
    check_eq("stall_flush_pc", if_pc, 32'h40);
    for (int i = 0; i < 3; i++) begin
      step(); check_eq("stall_hold", if_pc, 32'h40);
    end
    stall = 0;
    step(); check_eq("unstall_pc", if_pc, 32'h44);

    // aliasing: 0x50 shares slot 4 with 0x10 and evicts it
    drive_ex(1, 0, 0, 1, 32'h50, 32'h80, 0, 32'h54);
    check_eq("alias_flush", {31'b0, pipeline_flush}, 32'd1);
    step(); ex_idle();
    check_eq("alias_pc", if_pc, 32'h80);
    redirect(32'h10);
    check_eq("evict_pred", {31'b0, if_pred_taken}, 32'd0);
    check_eq("evict_tgt", if_pred_target, 32'h14);
    drive_ex(1, 0, 0, 1, 32'h10, 32'h40, 0, 32'h14);
    check_eq("evict_flush", {31'b0, pipeline_flush}, 32'd1);
    step(); ex_idle();
    redirect(32'h50);
    check_eq("evict2_pred", {31'b0, if_pred_taken}, 32'd0);

    // wrap: 0xFFFF_FFFC + 4 = 0
    redirect(32'hFFFF_FFFC);
    check_eq("wrap_pred", {31'b0, if_pred_taken}, 32'd0);
    check_eq("wrap_tgt", if_pred_target, 32'h0);
    step(); check_eq("wrap_pc", if_pc, 32'h0);

    // reset during a flush discards the redirect and clears the BTB
    drive_ex(1, 0, 0, 1, 32'h10, 32'h300, 0, 32'h14);
    #1 rst_n = 0;
    #1;
    check_eq("midrst_pc", if_pc, 32'h0);
    ex_idle();
    @(negedge clk); rst_n = 1;
    step(); check_eq("midrst_next", if_pc, 32'h4);
    redirect(32'h20);
    check_eq("midrst_btb", {31'b0, if_pred_taken}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
